// File: rtl/demap_pack.sv
// Hard-decision QPSK/16QAM demapper and MSB-first byte packer.
// Drops the leading pilots of each OFDM symbol and emits packed bytes over a Wishbone-style master port.
module demap_pack #(
    parameter int          N_SC  = 200,
    parameter int          N_PIL = 8,
    parameter logic [15:0] TH16  = 16'h143D
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [31:0] DAT_I,
    input  logic        WE_I,
    input  logic        STB_I,
    input  logic        CYC_I,
    output logic        ACK_O,
    input  logic        MOD_I,
    output logic [7:0]  DAT_O,
    output logic        CYC_O,
    output logic        STB_O,
    output logic        WE_O,
    input  logic        ACK_I
);

    localparam int SCW = $clog2(N_SC);
    localparam logic signed [15:0] TH_POS = TH16;
    localparam logic signed [15:0] TH_NEG = -TH16;

    logic [SCW-1:0] sc_cnt_q, sc_cnt_d;
    logic           mod_q, mod_d;
    logic [7:0]     acc_q, acc_d;
    logic [2:0]     bcnt_q, bcnt_d;
    logic [7:0]     dat_q, dat_d;
    logic           stb_q, stb_d;
    logic           cyc_o_q, cyc_o_d;
    logic           cyc_in_q;

    logic           in_val;
    logic           stall;
    logic           consume;
    logic           frame_start;
    logic           data_consume;
    logic           byte_done;
    logic [SCW-1:0] sc_eff;
    logic [7:0]     acc_base;
    logic [2:0]     bcnt_base;
    logic [7:0]     acc_shift;
    logic [3:0]     bcnt_sum;
    logic [1:0]     sgn;
    logic [1:0]     mag;

    assign in_val      = WE_I & STB_I & CYC_I;
    assign stall       = stb_q & ~ACK_I;
    assign consume     = in_val & ~stall;
    assign ACK_O       = consume;
    assign frame_start = CYC_I & ~cyc_in_q;

    // A sample arriving on the frame-start cycle is subcarrier 0 with an empty accumulator.
    assign sc_eff    = frame_start ? '0 : sc_cnt_q;
    assign acc_base  = frame_start ? 8'h00 : acc_q;
    assign bcnt_base = frame_start ? 3'd0 : bcnt_q;

    // Axis 0 is Re (DAT_I[15:0]), axis 1 is Im (DAT_I[31:16]).
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_axis
            logic signed [15:0] axis;
            assign axis    = DAT_I[16*gi +: 16];
            assign sgn[gi] = axis[15];
            assign mag[gi] = (axis >= TH_POS) || (axis <= TH_NEG);
        end
    endgenerate

    assign data_consume = consume && (sc_eff >= SCW'(N_PIL));
    assign acc_shift    = mod_q ? {acc_base[3:0], sgn[0], mag[0], sgn[1], mag[1]}
                                : {acc_base[5:0], sgn[0], sgn[1]};
    assign bcnt_sum     = {1'b0, bcnt_base} + (mod_q ? 4'd4 : 4'd2);
    assign byte_done    = data_consume & bcnt_sum[3];

    always_comb begin
        sc_cnt_d = sc_cnt_q;
        mod_d    = mod_q;
        acc_d    = acc_base;
        bcnt_d   = bcnt_base;
        dat_d    = dat_q;
        stb_d    = stb_q;
        cyc_o_d  = cyc_o_q;

        if (frame_start) begin
            sc_cnt_d = '0;
        end
        if (consume) begin
            sc_cnt_d = (sc_eff == SCW'(N_SC - 1)) ? '0 : sc_eff + 1'b1;
            if (sc_eff == '0) begin
                mod_d = MOD_I;
            end
        end
        if (data_consume) begin
            acc_d  = acc_shift;
            bcnt_d = bcnt_sum[2:0];
        end
        // Losing CYC_I discards whatever partial byte was being built.
        if (!CYC_I) begin
            acc_d  = 8'h00;
            bcnt_d = 3'd0;
        end

        if (byte_done) begin
            dat_d   = acc_shift;
            stb_d   = 1'b1;
            cyc_o_d = 1'b1;
        end else begin
            if (stb_q && ACK_I) begin
                stb_d = 1'b0;
            end
            if (!CYC_I && (!stb_q || ACK_I)) begin
                cyc_o_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            sc_cnt_q <= '0;
            mod_q    <= 1'b0;
            acc_q    <= 8'h00;
            bcnt_q   <= 3'd0;
            dat_q    <= 8'h00;
            stb_q    <= 1'b0;
            cyc_o_q  <= 1'b0;
            cyc_in_q <= 1'b1;
        end else begin
            sc_cnt_q <= sc_cnt_d;
            mod_q    <= mod_d;
            acc_q    <= acc_d;
            bcnt_q   <= bcnt_d;
            dat_q    <= dat_d;
            stb_q    <= stb_d;
            cyc_o_q  <= cyc_o_d;
            cyc_in_q <= CYC_I;
        end
    end

    assign DAT_O = dat_q;
    assign STB_O = stb_q;
    assign CYC_O = cyc_o_q;
    assign WE_O  = cyc_o_q;

endmodule

// File: tb/tb_demap_pack.sv
// Directed bench for demap_pack: a spec-level model pushes expected bytes, a monitor pops them on each handshake.
module tb_demap_pack;

    logic        CLK_I = 1'b0;
    logic        RST_I = 1'b0;
    logic [31:0] DAT_I = '0;
    logic        WE_I  = 1'b0;
    logic        STB_I = 1'b0;
    logic        CYC_I = 1'b0;
    logic        ACK_O;
    logic        MOD_I = 1'b0;
    logic [7:0]  DAT_O;
    logic        CYC_O;
    logic        STB_O;
    logic        WE_O;
    logic        ACK_I = 1'b1;

    int tests = 0;
    int fails = 0;

    logic [7:0] sb[$];
    int         m_sc  = 0;
    logic       m_mod = 1'b0;
    logic [7:0] m_acc = 8'h00;
    int         m_n   = 0;

    demap_pack dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .DAT_I(DAT_I), .WE_I(WE_I), .STB_I(STB_I),
        .CYC_I(CYC_I), .ACK_O(ACK_O), .MOD_I(MOD_I), .DAT_O(DAT_O), .CYC_O(CYC_O),
        .STB_O(STB_O), .WE_O(WE_O), .ACK_I(ACK_I)
    );

    always #5 CLK_I = ~CLK_I;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit mag_bit(input logic [15:0] x);
        int v;
        v = int'($signed(x));
        return (v >= 5181) || (v <= -5181);
    endfunction

    task automatic push_bit(input bit b);
        m_acc = {m_acc[6:0], b};
        m_n++;
        if (m_n == 8) begin
            sb.push_back(m_acc);
            m_n = 0;
        end
    endtask

    task automatic model_consume(input logic [31:0] d);
        if (m_sc == 0) m_mod = MOD_I;
        if (m_sc >= 8) begin
            push_bit(d[15]);
            if (m_mod) push_bit(mag_bit(d[15:0]));
            push_bit(d[31]);
            if (m_mod) push_bit(mag_bit(d[31:16]));
        end
        m_sc = (m_sc == 199) ? 0 : m_sc + 1;
    endtask

    task automatic model_reset();
        m_sc  = 0;
        m_acc = 8'h00;
        m_n   = 0;
    endtask

    // Present one sample; optionally hold ACK_I low for 'stall' cycles first.
    task automatic send(input logic [31:0] d, input int stall);
        bit got;
        DAT_I = d; WE_I = 1'b1; STB_I = 1'b1; CYC_I = 1'b1;
        if (stall > 0) begin
            check("stall_stb_pending", STB_O, 1);
            ACK_I = 1'b0;
            repeat (stall) begin
                @(negedge CLK_I);
                check("stall_ack_o_low", ACK_O, 0);
            end
            @(posedge CLK_I); #1;
            ACK_I = 1'b1;
        end
        got = 0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge CLK_I);
            if (ACK_O) got = 1;
        end
        check("ack_timeout", 32'(got), 1);
        if (got) model_consume(d);
        @(posedge CLK_I); #1;
    endtask

    task automatic end_frame(input int n);
        CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
        model_reset();
        repeat (n) @(posedge CLK_I);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 200 && (sb.size() != 0 || STB_O); k++) @(posedge CLK_I);
        #1;
        check(tag, 32'(sb.size()), 0);
    endtask

    always @(negedge CLK_I) begin
        if (RST_I && STB_O && ACK_I) begin
            if (sb.size() == 0) begin
                check("unexpected_byte_sb_size", 32'(sb.size()), 1);
            end else begin
                logic [7:0] exp;
                exp = sb.pop_front();
                check("byte", DAT_O, exp);
                check("cyc_o_during_stb", CYC_O, 1);
                $display("[TB] byte %02h expected %02h", DAT_O, exp);
            end
        end
    end

    initial begin
        // Reset state
        #12;
        check("rst_dat_o", DAT_O, 8'h00);
        check("rst_stb_o", STB_O, 0);
        check("rst_cyc_o", CYC_O, 0);
        check("rst_we_o", WE_O, 0);
        check("rst_ack_o", ACK_O, 0);
        @(posedge CLK_I); #1;
        RST_I = 1'b1;
        @(posedge CLK_I); #1;

        // QPSK: 48 bytes of 8'h55, first STB_O one cycle after the 12th consume
        MOD_I = 1'b0;
        for (int i = 0; i < 200; i++) begin
            send((i < 8) ? 32'h7FFF7FFF : 32'hE99A1666, 0);
            if (i == 10) check("lat_stb_before", STB_O, 0);
            if (i == 11) begin
                check("lat_stb_first", STB_O, 1);
                check("lat_dat_first", DAT_O, 8'h55);
                check("cyc_o_first", CYC_O, 1);
            end
        end
        end_frame(2);
        drain("drain_qpsk");

        // 16QAM: 8'h66 per byte, with a 5-cycle backpressure stall
        MOD_I = 1'b1;
        for (int i = 0; i < 200; i++)
            send((i < 8) ? 32'h7FFF7FFF : 32'hF0002000, (i == 20) ? 5 : 0);
        end_frame(2);
        drain("drain_16qam");

        // Threshold edges: {143D,143C} -> 0100, {EBC3,EBC4} -> 1110, byte 8'h4E
        for (int i = 0; i < 200; i++)
            send((i < 8) ? 32'h00000000 : ((i % 2 == 0) ? 32'h143C143D : 32'hEBC4EBC3), 0);
        end_frame(2);
        drain("drain_thresh");

        // MOD_I changed mid-symbol takes effect on the next symbol only
        MOD_I = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (i == 100) MOD_I = 1'b1;
            send($urandom, 0);
        end
        end_frame(2);
        drain("drain_modsw");

        // Abort after 50 samples, then restart at the pilot count
        MOD_I = 1'b0;
        for (int i = 0; i < 50; i++) send($urandom, 0);
        end_frame(3);
        drain("drain_abort");
        repeat (3) @(posedge CLK_I);
        #1;
        check("abort_cyc_o_low", CYC_O, 0);
        check("abort_we_o_low", WE_O, 0);
        MOD_I = 1'b1;
        for (int i = 0; i < 200; i++) send($urandom, 0);
        end_frame(2);
        drain("drain_restart");

        // Asynchronous reset mid-frame
        MOD_I = 1'b1;
        for (int i = 0; i < 30; i++) send($urandom, 0);
        STB_I = 1'b0;
        #2;
        RST_I = 1'b0;
        #1;
        check("mid_rst_dat_o", DAT_O, 8'h00);
        check("mid_rst_stb_o", STB_O, 0);
        check("mid_rst_cyc_o", CYC_O, 0);
        check("mid_rst_we_o", WE_O, 0);
        check("mid_rst_ack_o", ACK_O, 0);
        sb.delete();
        model_reset();
        @(posedge CLK_I); #1;
        RST_I = 1'b1;
        end_frame(2);
        MOD_I = 1'b0;
        for (int i = 0; i < 200; i++) send($urandom, 0);
        end_frame(2);
        drain("drain_post_rst");
        repeat (3) @(posedge CLK_I);
        #1;
        check("final_cyc_o", CYC_O, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/demap_pack.md
# demap_pack

Receive-path stage directly downstream of the channel estimator/equalizer. It accepts equalized subcarriers (Q3.13 complex), one per handshake, in equalizer output order: 8 pilots first, then 192 data carriers per 200-subcarrier OFDM symbol. It drops the pilots, makes a hard-decision QPSK or 16QAM demap of each data carrier, and packs the bits MSB-first into bytes for the deinterleaver/decoder.

## Interface
- N_SC, 200: subcarriers per OFDM symbol on the input.
- N_PIL, 8: leading pilots per symbol to discard.
- TH16, 16'h143D: 16QAM inner/outer decision threshold, 2/sqrt(10) in Q3.13.

- CLK_I  in  1: clock; all state changes on the rising edge.
- RST_I  in  1: reset, asynchronous, active-low.
- DAT_I  in  32: [31:16] Im, [15:0] Re, signed Q3.13.
- WE_I, STB_I, CYC_I  in  1 each: upstream master strobes; CYC_I high spans a frame.
- ACK_O  out  1: input sample accepted this cycle (combinational).
- MOD_I  in  1: 0 = QPSK, 1 = 16QAM; sampled per symbol.
- DAT_O  out  8: packed byte.
- CYC_O, STB_O, WE_O  out  1 each: output master strobes; WE_O = CYC_O.
- ACK_I  in  1: downstream accepts DAT_O.

## Operation
- Signal definitions:
  - `in_val` = WE_I & STB_I & CYC_I.
  - `stall` = STB_O & ~ACK_I.
  - ACK_O = `in_val` & ~`stall`.
  - A sample is consumed only when ACK_O = 1.
- Frame start: on a rising edge of CYC_I (registered CYC_I was low), clear the subcarrier counter `sc_cnt`, the bit accumulator and the bit count. A sample presented in that same cycle is counted as subcarrier 0.
- `sc_cnt` (0..N_SC-1) increments on each consumed sample and wraps N_SC-1 -> 0.
- At `sc_cnt` = 0 on consume, latch MOD_I into `mod_r`. That value holds for the whole symbol; MOD_I changes mid-symbol are ignored.
- Samples with `sc_cnt` < N_PIL are acknowledged and discarded. They produce no bits.
- Data carriers:
  - Per axis x (Re, then Im):
    - sign bit s = x[15].
    - magnitude bit m = (x >= TH16) | (x <= -TH16), as a signed 16-bit compare.
  - QPSK emits {s_Re, s_Im} (2 bits).
  - 16QAM emits {s_Re, m_Re, s_Im, m_Im} (4 bits).
  - Leftmost bit is emitted first.
- Packing:
  - Bits shift into an 8-bit accumulator MSB-first, so the first bit lands in DAT_O[7].
  - Each byte takes 4 carriers (QPSK) or 2 carriers (16QAM).
  - A symbol yields exactly 48 or 96 bytes; no partial byte exists at a symbol boundary.
- When a consume completes a byte: DAT_O <= byte and STB_O <= 1 on the next edge.
- STB_O/DAT_O hold until ACK_I = 1.
  - If ACK_I = 1 and no new byte completes in the same cycle, STB_O <= 0.
  - If ACK_I = 1 and a new byte completes in the same cycle, DAT_O is reloaded and STB_O stays 1.
- CYC_O:
  - Set with the first STB_O of a frame.
  - Cleared on the cycle after the last byte is acknowledged while CYC_I is low and the accumulator is empty.
- Abort: if CYC_I falls mid-symbol, the partial accumulator contents are discarded. A byte already on DAT_O is still delivered.

## Timing
- Reset values: DAT_O = 8'h00, STB_O = 0, CYC_O = 0, WE_O = 0. ACK_O = 0 while `in_val` = 0. Internal counters and `mod_r` = 0.
- Latency: the consume of the byte-completing carrier -> STB_O high on the next edge (1 cycle).
- Throughput: 1 carrier per cycle. Backpressure propagates combinationally: ACK_O drops in the same cycle that `stall` is high.
- Reset asserted mid-frame: all state clears immediately. After release, the block waits for a new CYC_I rising edge (a registered CYC_I resets to 1, so a high CYC_I at release is not treated as a start).
- Simultaneous frame start and byte pending on DAT_O: the pending byte is delivered normally; the accumulator still clears.

## Test plan
- QPSK, 200 samples, pilots = 32'h7FFF7FFF, data alternating Re = +0.7 (16'h1666) / Im = -0.7 (16'hE99A), ACK_I tied 1 -> 48 bytes of 8'h55, first STB_O 1 cycle after the 12th consume (8 pilots + 4 data).
- 16QAM, data carrier Re = 16'h2000 (+1.0), Im = 16'hF000 (-0.5) -> bits 0,1,1,0 per carrier, bytes 8'h66, 96 bytes per symbol.
- Threshold edges:
  - Re = 16'h143D -> m = 1.
  - Re = 16'h143C -> m = 0.
  - Re = 16'hEBC3 (-TH16) -> m = 1.
- Backpressure: ACK_I held low 5 cycles while a byte is pending -> ACK_O low for those 5 cycles, no sample lost, byte sequence identical to the no-stall run.
- MOD_I toggled at `sc_cnt` = 100 -> ignored for the current symbol; the next symbol uses the new mode.
- CYC_I dropped after 50 samples, then re-raised -> the pending partial byte is discarded and the new frame restarts at the pilot count. Separately, RST_I pulsed low mid-frame -> all outputs return to their reset values asynchronously.
